// File: rtl/fifo_ptr_flag_ctrl.sv
// rtl/fifo_ptr_flag_ctrl.sv - single-clock FIFO pointer, occupancy and registered flag controller
module fifo_ptr_flag_ctrl #(
    parameter int A_LENGTH = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic                rd_en,
    output logic                wr_accept,
    output logic                rd_accept,
    output logic [A_LENGTH-1:0] wr_ptr,
    output logic [A_LENGTH-1:0] rd_ptr,
    output logic [A_LENGTH:0]   count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 2 ** A_LENGTH;
    localparam logic [A_LENGTH:0]   DEPTH_C = (A_LENGTH + 1)'(DEPTH);
    localparam logic [A_LENGTH:0]   AF_C    = (A_LENGTH + 1)'(AF_LEVEL);
    localparam logic [A_LENGTH:0]   AE_C    = (A_LENGTH + 1)'(AE_LEVEL);
    localparam logic [A_LENGTH:0]   CNT_ONE = (A_LENGTH + 1)'(1);
    localparam logic [A_LENGTH-1:0] PTR_ONE = A_LENGTH'(1);

    logic [A_LENGTH:0] count_nxt;

    // Accepts are gated by the registered flags, so they never depend on this cycle's update.
    assign wr_accept = wr_en & ~full;
    assign rd_accept = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
            count        <= count_nxt;
            // Flags follow next-count so they describe occupancy in the cycle after the access.
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_flag_ctrl.sv
// tb/tb_fifo_ptr_flag_ctrl.sv - directed and scoreboard checks for fifo_ptr_flag_ctrl
module tb_fifo_ptr_flag_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic       rd_en;
    logic       wr_accept;
    logic       rd_accept;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_ptr_flag_ctrl #(.A_LENGTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
        .wr_accept(wr_accept), .rd_accept(rd_accept),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_en = 1'b1; rd_en = 1'b0;
        tick(); tick();
        n_checks++; if (wr_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_wr_ptr got %0d exp 0", wr_ptr); end
        n_checks++; if (rd_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_rd_ptr got %0d exp 0", rd_ptr); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got %b exp 1", almost_empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b exp 00", {overflow, underflow}); end
        wr_en = 1'b0; reset_n = 1'b1;
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_release_count got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            wr_en = 1'b1; #1;
            n_checks++; if (wr_accept !== 1'b1) begin n_fail++; $display("FAIL fill_wr_accept[%0d] got %b exp 1", k, wr_accept); end
            tick();
            n_checks++; if (count !== 4'(k)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, k); end
            n_checks++; if (wr_ptr !== 3'(k % 8)) begin n_fail++; $display("FAIL fill_wr_ptr[%0d] got %0d exp %0d", k, wr_ptr, k % 8); end
            n_checks++; if (almost_empty !== (k <= 2)) begin n_fail++; $display("FAIL fill_almost_empty[%0d] got %b exp %b", k, almost_empty, k <= 2); end
            n_checks++; if (almost_full !== (k >= 6)) begin n_fail++; $display("FAIL fill_almost_full[%0d] got %b exp %b", k, almost_full, k >= 6); end
            n_checks++; if (full !== (k == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", k, full, k == 8); end
            n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d] got %b exp 0", k, empty); end
        end
        #1;
        n_checks++; if (wr_accept !== 1'b0) begin n_fail++; $display("FAIL ninth_wr_accept got %b exp 0", wr_accept); end
        tick();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ninth_overflow got %b exp 1", overflow); end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ninth_count got %0d exp 8", count); end
        n_checks++; if (wr_ptr !== 3'd0) begin n_fail++; $display("FAIL ninth_wr_ptr got %0d exp 0", wr_ptr); end
        wr_en = 1'b0;
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got %b exp 0", overflow); end
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 8; k++) begin
            rd_en = 1'b1; #1;
            n_checks++; if (rd_accept !== 1'b1) begin n_fail++; $display("FAIL drain_rd_accept[%0d] got %b exp 1", k, rd_accept); end
            tick();
            n_checks++; if (count !== 4'(8 - k)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", k, count, 8 - k); end
            n_checks++; if (rd_ptr !== 3'(k % 8)) begin n_fail++; $display("FAIL drain_rd_ptr[%0d] got %0d exp %0d", k, rd_ptr, k % 8); end
            n_checks++; if (empty !== (k == 8)) begin n_fail++; $display("FAIL drain_empty[%0d] got %b exp %b", k, empty, k == 8); end
            n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full[%0d] got %b exp 0", k, full); end
        end
        #1;
        n_checks++; if (rd_accept !== 1'b0) begin n_fail++; $display("FAIL extra_rd_accept got %b exp 0", rd_accept); end
        tick();
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL extra_underflow got %b exp 1", underflow); end
        n_checks++; if (rd_ptr !== 3'd0) begin n_fail++; $display("FAIL extra_rd_ptr got %0d exp 0", rd_ptr); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL extra_count got %0d exp 0", count); end
        rd_en = 1'b0;
        tick();
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b exp 0", underflow); end
    endtask

    task automatic test_simultaneous();
        // Pointers start at wr=0, rd=0, count=0.
        wr_en = 1'b1; repeat (4) tick(); wr_en = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; repeat (5) tick(); wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL sim_mid_count got %0d exp 4", count); end
        n_checks++; if (wr_ptr !== 3'd1) begin n_fail++; $display("FAIL sim_mid_wr_ptr got %0d exp 1", wr_ptr); end
        n_checks++; if (rd_ptr !== 3'd5) begin n_fail++; $display("FAIL sim_mid_rd_ptr got %0d exp 5", rd_ptr); end
        wr_en = 1'b1; repeat (4) tick(); wr_en = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL sim_prefull got %b exp 1", full); end
        wr_en = 1'b1; rd_en = 1'b1; tick(); wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL sim_full_count got %0d exp 7", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sim_full_overflow got %b exp 1", overflow); end
        n_checks++; if (wr_ptr !== 3'd5) begin n_fail++; $display("FAIL sim_full_wr_ptr got %0d exp 5", wr_ptr); end
        n_checks++; if (rd_ptr !== 3'd6) begin n_fail++; $display("FAIL sim_full_rd_ptr got %0d exp 6", rd_ptr); end
        rd_en = 1'b1; repeat (7) tick(); rd_en = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_preempty got %b exp 1", empty); end
        wr_en = 1'b1; rd_en = 1'b1; tick(); wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL sim_empty_count got %0d exp 1", count); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL sim_empty_underflow got %b exp 1", underflow); end
        n_checks++; if (wr_ptr !== 3'd6) begin n_fail++; $display("FAIL sim_empty_wr_ptr got %0d exp 6", wr_ptr); end
        n_checks++; if (rd_ptr !== 3'd5) begin n_fail++; $display("FAIL sim_empty_rd_ptr got %0d exp 5", rd_ptr); end
        tick();
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL sim_underflow_clear got %b exp 0", underflow); end
    endtask

    task automatic test_mid_reset();
        wr_en = 1'b1; repeat (4) tick(); wr_en = 1'b0;
        n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL mrst_pre_count got %0d exp 5", count); end
        reset_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        reset_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if ({wr_ptr, rd_ptr, count} !== 10'd0) begin n_fail++; $display("FAIL mrst_state got wr=%0d rd=%0d cnt=%0d exp 0/0/0", wr_ptr, rd_ptr, count); end
        n_checks++; if ({full, empty, almost_full, almost_empty, overflow, underflow} !== 6'b010100) begin
            n_fail++; $display("FAIL mrst_flags got %b exp 010100", {full, empty, almost_full, almost_empty, overflow, underflow});
        end
    endtask

    task automatic test_stress();
        int m_cnt = 0, m_wp = 0, m_rp = 0;
        logic m_ovf = 1'b0, m_unf = 1'b0;
        logic w, r, wa, ra;
        for (int i = 0; i < 3000; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            wr_en = w; rd_en = r;
            wa = w && (m_cnt != 8);
            ra = r && (m_cnt != 0);
            m_ovf = w && (m_cnt == 8);
            m_unf = r && (m_cnt == 0);
            if (wa) m_wp = (m_wp + 1) % 8;
            if (ra) m_rp = (m_rp + 1) % 8;
            m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
            tick();
            n_checks++;
            if ({wr_ptr, rd_ptr, count} !== {3'(m_wp), 3'(m_rp), 4'(m_cnt)}) begin
                n_fail++; $display("FAIL stress_state[%0d] got wr=%0d rd=%0d cnt=%0d exp %0d/%0d/%0d", i, wr_ptr, rd_ptr, count, m_wp, m_rp, m_cnt);
            end
            n_checks++;
            if ({full, empty, almost_full, almost_empty, overflow, underflow} !==
                {m_cnt == 8, m_cnt == 0, m_cnt >= 6, m_cnt <= 2, m_ovf, m_unf}) begin
                n_fail++; $display("FAIL stress_flags[%0d] got %b cnt=%0d", i, {full, empty, almost_full, almost_empty, overflow, underflow}, m_cnt);
            end
            n_checks++;
            if ((3'(wr_ptr - rd_ptr) !== count[2:0]) || (full && empty)) begin
                n_fail++; $display("FAIL stress_invariant[%0d] got wr=%0d rd=%0d cnt=%0d", i, wr_ptr, rd_ptr, count);
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_mid_reset();
        test_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
